// File: rtl/core_inst_pkg.sv
// core_inst_pkg: instruction bit positions, idle word, sequencer states and field bundle.
package core_inst_pkg;
  localparam int ADDR_W = 11;
  localparam int B_PASS_PSUM = 39;
  localparam int B_RECALL_PSUM = 38;
  localparam int B_L1_WR = 37;
  localparam int B_OUT_STAT = 36;
  localparam int B_REN_PMEM = 35;
  localparam int B_PASSTHRU = 34;
  localparam int B_ACC = 33;
  localparam int B_CEN_PMEM = 32;
  localparam int B_WEN_PMEM = 31;
  localparam int B_A_PMEM = 20;
  localparam int B_CEN_XMEM = 19;
  localparam int B_WEN_XMEM = 18;
  localparam int B_A_XMEM = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD = 3;
  localparam int B_L0_WR = 2;
  localparam int B_EXECUTE = 1;
  localparam int B_LOAD = 0;
  localparam logic [63:0] IDLE_INST = 64'h0000_0001_800C_0000;
  typedef enum logic [2:0] {IDLE, W_FETCH, W_LOAD, A_FETCH, EXEC, DRAIN_RD, DRAIN_WR, FIN} state_t;
  typedef struct packed {
    logic cen_x;
    logic [ADDR_W-1:0] a_x;
    logic l0_wr;
    logic load;
    logic l0_rd;
    logic execute;
    logic cen_p;
    logic ren_p;
    logic wen_p;
    logic [ADDR_W-1:0] a_p;
    logic ofifo_rd;
    logic acc;
    logic pass;
  } fields_t;
endpackage

// File: rtl/core_inst_pack.sv
// core_inst_pack: places named fields into the 64-bit core instruction word.
module core_inst_pack
  import core_inst_pkg::*;
(
  input  fields_t     f_i,
  output logic [63:0] inst_o
);
  always_comb begin
    inst_o = IDLE_INST;
    inst_o[B_CEN_XMEM] = f_i.cen_x;
    inst_o[B_A_XMEM +: ADDR_W] = f_i.a_x;
    inst_o[B_L0_WR] = f_i.l0_wr;
    inst_o[B_LOAD] = f_i.load;
    inst_o[B_L0_RD] = f_i.l0_rd;
    inst_o[B_EXECUTE] = f_i.execute;
    inst_o[B_CEN_PMEM] = f_i.cen_p;
    inst_o[B_REN_PMEM] = f_i.ren_p;
    inst_o[B_WEN_PMEM] = f_i.wen_p;
    inst_o[B_A_PMEM +: ADDR_W] = f_i.a_p;
    inst_o[B_OFIFO_RD] = f_i.ofifo_rd;
    inst_o[B_ACC] = f_i.acc;
    inst_o[B_PASSTHRU] = f_i.pass;
  end
endmodule

// File: rtl/core_seq.sv
// core_seq: weight-stationary tile sequencer emitting one registered instruction word per cycle.
module core_seq
  import core_inst_pkg::*;
#(
  parameter int ROW = 8,
  parameter int MAX_ACT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] p_base,
  input  logic [4:0]        num_act,
  input  logic              acc_en,
  input  logic              ofifo_valid,
  output logic [63:0]       inst,
  output logic              busy,
  output logic              done
);
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d, last;
  logic [4:0] n_q, n_d, k_q, k_d, n_in;
  logic [ADDR_W-1:0] wb_q, wb_d, ab_q, ab_d, pb_q, pb_d;
  logic acc_q, acc_d, rd_q, rd_d, done_q, fetch_x, wr_p;
  logic [63:0] inst_q, inst_d;
  fields_t f;
  // Everything below is decided from the next state, so the word lands with the state.
  always_comb begin
    n_in = num_act > 5'(MAX_ACT) ? 5'(MAX_ACT) : num_act;
    state_d = state_q;
    cnt_d = '0;
    k_d = k_q;
    n_d = n_q;
    wb_d = wb_q;
    ab_d = ab_q;
    pb_d = pb_q;
    acc_d = acc_q;
    last = state_q == W_FETCH ? 8'(ROW) : state_q == W_LOAD ? 8'(2*ROW-2) :
           state_q == A_FETCH ? 8'(n_q) : 8'(n_q) - 8'd1;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = n_in == '0 ? FIN : W_FETCH;
        n_d = n_in;
        wb_d = w_base;
        ab_d = a_base;
        pb_d = p_base;
        acc_d = acc_en;
      end
    end else if (state_q inside {W_FETCH, W_LOAD, A_FETCH, EXEC}) begin
      if (cnt_q == last) begin
        k_d = '0;
        state_d = state_q == W_FETCH ? W_LOAD : state_q == W_LOAD ? A_FETCH :
                  state_q == A_FETCH ? EXEC : DRAIN_RD;
      end else cnt_d = cnt_q + 8'd1;
    end else if (state_q == DRAIN_RD) begin
      if (rd_q) state_d = DRAIN_WR;
    end else if (state_q == DRAIN_WR) begin
      k_d = k_q + 5'd1;
      state_d = k_d == n_q ? FIN : DRAIN_RD;
    end else state_d = IDLE;
    rd_d = state_d == DRAIN_RD && ofifo_valid;
    wr_p = state_d == DRAIN_WR;
    fetch_x = (state_d == W_FETCH && cnt_d < 8'(ROW)) || (state_d == A_FETCH && cnt_d < 8'(n_d));
    f.cen_x = ~fetch_x;
    f.a_x = fetch_x ? (state_d == W_FETCH ? wb_d : ab_d) + ADDR_W'(cnt_d) : '0;
    f.l0_wr = state_d inside {W_FETCH, A_FETCH} && cnt_d != '0;
    f.load = state_d == W_LOAD;
    f.l0_rd = (state_d == W_LOAD && cnt_d < 8'(ROW)) || state_d == EXEC;
    f.execute = state_d == EXEC;
    f.cen_p = ~(rd_d | wr_p);
    f.ren_p = rd_d;
    f.wen_p = ~wr_p;
    f.a_p = (rd_d | wr_p) ? pb_d + ADDR_W'(k_d) : '0;
    f.ofifo_rd = wr_p;
    f.acc = wr_p & acc_d;
    f.pass = wr_p & ~acc_d;
  end
  core_inst_pack u_pack (.f_i(f), .inst_o(inst_d));
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      n_q <= '0;
      k_q <= '0;
      wb_q <= '0;
      ab_q <= '0;
      pb_q <= '0;
      acc_q <= 1'b0;
      rd_q <= 1'b0;
      done_q <= 1'b0;
      inst_q <= IDLE_INST;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      n_q <= n_d;
      k_q <= k_d;
      wb_q <= wb_d;
      ab_q <= ab_d;
      pb_q <= pb_d;
      acc_q <= acc_d;
      rd_q <= rd_d;
      done_q <= state_d == FIN;
      inst_q <= inst_d;
    end
  end
  assign inst = inst_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
endmodule
